// File: rtl/array_loader_n.sv
// Serial-to-parallel loader: fills an m-entry register array from a valid/ready
// stream, then freezes it and hands it to a downstream scanner until done_i.
module array_loader_n #(
    parameter int n  = 4,
    parameter int m  = 10,
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [n-1:0]  data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [n-1:0]  data_o [0:m-1],
    output logic [3:0]    wr_ptr_o,
    output logic          full_o,
    output logic          start_o,
    input  logic          done_i,
    output logic [BW-1:0] blk_cnt_o
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] LAST = 4'(m - 1);

    state_e        state_q, state_d;
    logic [n-1:0]  data_q [0:m-1];
    logic [n-1:0]  data_d [0:m-1];
    logic [3:0]    ptr_q, ptr_d;
    logic          start_q, start_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          accept;

    // Writes only happen in FILL; HOLD just waits for the scanner to release it.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        start_d = 1'b0;
        blk_d   = blk_q;
        accept  = valid_i && (state_q == FILL);

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < m; i++) begin
                        if (ptr_q == 4'(i)) begin
                            data_d[i] = data_i;
                        end
                    end
                    if (ptr_q == LAST) begin
                        ptr_d   = '0;
                        state_d = HOLD;
                        start_d = 1'b1;
                        blk_d   = blk_q + BW'(1);
                    end else begin
                        ptr_d = ptr_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (done_i) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL;
            for (int i = 0; i < m; i++) begin
                data_q[i] <= '0;
            end
            ptr_q   <= '0;
            start_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            blk_q   <= blk_d;
        end
    end

    // Handshake flags come straight from the state register, never from inputs.
    assign ready_o   = (state_q == FILL);
    assign full_o    = (state_q == HOLD);
    assign data_o    = data_q;
    assign wr_ptr_o  = ptr_q;
    assign start_o   = start_q;
    assign blk_cnt_o = blk_q;

endmodule

// File: doc/array_loader_n.md
Name: array_loader_n

Overview:
- Producer end of the parallel-array interface used by the min/index scanners.
- Accepts a serial stream of n-bit samples over a valid/ready handshake and writes them into an m-entry register array.
- Once the array is full, it freezes the contents, pulses start_o, and holds until the downstream scanner signals completion on done_i.
- It then re-opens for the next block.

Parameters:
- n, 4, sample width in bits
- m, 10, number of array entries (2..15; pointer is 4 bits)
- BW, 8, width of the completed-block counter

Ports:
- clk_i  input  1  single system clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- data_i  input  n  serial sample
- valid_i  input  1  data_i valid this cycle
- ready_o  output  1  loader can accept a sample this cycle
- data_o  output  m x n  unpacked array data_o[0:m-1] to scanner
- wr_ptr_o  output  4  index of next entry to be written
- full_o  output  1  array complete and frozen (HOLD state)
- start_o  output  1  one-cycle pulse: new full array available
- done_i  input  1  scanner finished with current array (e.g. its end flag)
- blk_cnt_o  output  BW  number of blocks handed off, modulo 2^BW

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All data_o entries = 0, wr_ptr_o = 0, full_o = 0, start_o = 0, blk_cnt_o = 0.
  - State = FILL, so ready_o = 1 from the first cycle after reset release.
- States:
  - FILL: ready_o = 1, full_o = 0.
  - HOLD: ready_o = 0, full_o = 1.
  - ready_o and full_o are decoded from state registers (no combinational path from valid_i or done_i).
- Accept rule: a transfer occurs on a clock edge where valid_i = 1 and ready_o = 1.
  - data_o[wr_ptr_o] <= data_i.
  - wr_ptr_o <= wr_ptr_o + 1.
  - valid_i while ready_o = 0 is ignored; the source must hold the sample until a transfer occurs.
- Last-entry accept (FILL, transfer with wr_ptr_o = m-1):
  - wr_ptr_o wraps to 0.
  - State -> HOLD.
  - start_o = 1 for exactly the following cycle.
  - blk_cnt_o increments on the same edge, wrapping at 2^BW.
- Latency: the written entry is visible on data_o the cycle after the accepting edge. full_o and start_o rise the cycle after the m-th accept.
- HOLD:
  - All data_o entries and wr_ptr_o are frozen.
  - On an edge with done_i = 1, state -> FILL, so ready_o = 1 from the next cycle.
  - Releasing on the same edge as start_o (done_i already high) is permitted: HOLD lasts minimum one cycle.
- done_i in FILL: ignored, with no effect on pointer or data.
- Array contents are not cleared between blocks. Entries are overwritten in order 0..m-1 during the next FILL.
- Reset mid-FILL or mid-HOLD: immediate return to the reset values. No partial block is counted and no start_o is issued.
- No combinational path from data_i to any output.

Test Plan:
- Reset, then 10 back-to-back transfers of 9,8,...,0 (valid_i held high):
  - ready_o = 1 throughout.
  - Cycle after 10th accept: data_o = {9,8,...,0}, full_o = 1, start_o = 1 for one cycle, wr_ptr_o = 0, blk_cnt_o = 1.
- In HOLD, drive valid_i = 1 with data_i = 5 for 20 cycles:
  - ready_o = 0 and data_o unchanged.
  - Assert done_i for one cycle: ready_o = 1 on the next cycle, full_o = 0.
- Gappy stream with valid_i toggling 1/0, samples 3,7,1,...:
  - Entries land in order with no duplicates.
  - wr_ptr_o advances only on valid cycles.
  - start_o fires after the 10th valid sample only.
- done_i held high continuously:
  - HOLD lasts exactly 1 cycle.
  - Second block of 10 samples overwrites all entries.
  - blk_cnt_o = 2.
- Assert rst_i = 0 asynchronously after 6 accepts, then release:
  - All outputs at reset values immediately.
  - Next 10 accepts produce one full block, blk_cnt_o = 1.
- Run 256 blocks with BW = 8: blk_cnt_o wraps to 0 and start_o count = 256.
